// File: rtl/gpio_ctrl_if.sv
// CPU load/store bus bundle for the GPIO controller.
// Master drives address/data/strobe; slave returns combinational read data.
interface gpio_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata
  );
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: direction, atomic set/clear/toggle,
// synchronised inputs with edge capture and a level interrupt.
module gpio_ctrl #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0030
) (
  input  logic             clk,
  input  logic             rst,
  gpio_ctrl_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [3:0] {
    R_OUT  = 4'd0,
    R_DIR  = 4'd1,
    R_IN   = 4'd2,
    R_SET  = 4'd3,
    R_CLR  = 4'd4,
    R_TGL  = 4'd5,
    R_REN  = 4'd6,
    R_FEN  = 4'd7,
    R_STAT = 4'd8
  } reg_e;

  logic [31:0]      off;
  logic [3:0]       idx;
  logic             hit;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wdata;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] ren_q;
  logic [WIDTH-1:0] fen_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] p;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd;

  assign off = bus.addr - BASE_ADDR;
  assign idx = off[5:2];
  // Subtraction wraps below the base, so also require addr >= base.
  assign hit = (bus.addr >= BASE_ADDR)
            && (off[31:6] == '0)
            && (off[1:0] == 2'b00)
            && (idx <= R_STAT);
  assign wr  = bus.we && hit;
  assign wd  = bus.wdata[WIDTH-1:0];
  assign unused_wdata = ^bus.wdata;

  assign rise = s2 & ~p;
  assign fall = ~s2 & p;
  assign clr  = (wr && idx == R_STAT) ? wd : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      p  <= '0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
      p  <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      dir_q <= '0;
      ren_q <= '0;
      fen_q <= '0;
    end else if (wr) begin
      unique case (idx)
        R_OUT:   out_q <= wd;
        R_DIR:   dir_q <= wd;
        R_SET:   out_q <= out_q | wd;
        R_CLR:   out_q <= out_q & ~wd;
        R_TGL:   out_q <= out_q ^ wd;
        R_REN:   ren_q <= wd;
        R_FEN:   fen_q <= wd;
        default: ;
      endcase
    end
  end

  // New edges are OR'd after the W1C mask so they win a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= (stat_q & ~clr)
              | (rise & ren_q)
              | (fall & fen_q);
    end
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (idx)
        R_OUT:   rd = out_q;
        R_DIR:   rd = dir_q;
        R_IN:    rd = s2;
        R_REN:   rd = ren_q;
        R_FEN:   rd = fen_q;
        R_STAT:  rd = stat_q;
        default: rd = '0;
      endcase
    end
  end

  assign bus.rdata = 32'(rd);
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = |stat_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed and randomised checks of gpio_ctrl against a
// cycle-level behavioural model of the register map.
module tb_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0030;

  logic       clk;
  logic       rst;
  logic [7:0] pins;
  logic [7:0] gout;
  logic [7:0] goe;
  logic       irq;

  int total;
  int passed;
  int fails;

  gpio_ctrl_if bus ();

  gpio_ctrl #(
    .WIDTH(8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .gpio_in(pins),
    .gpio_out(gout),
    .gpio_oe(goe),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_out, m_dir, m_ren, m_fen, m_stat;
  logic [7:0] ph[$];

  function automatic bit m_hit(logic [31:0] a);
    return (a >= BASE) && (a - BASE <= 32'h20) && (a[1:0] == 2'b00);
  endfunction

  task automatic model_reset();
    m_out  = '0;
    m_dir  = '0;
    m_ren  = '0;
    m_fen  = '0;
    m_stat = '0;
    ph     = '{8'h00, 8'h00, 8'h00};
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case (a - BASE)
      32'h00:  return {24'h0, m_out};
      32'h04:  return {24'h0, m_dir};
      32'h08:  return {24'h0, ph[1]};
      32'h18:  return {24'h0, m_ren};
      32'h1C:  return {24'h0, m_fen};
      32'h20:  return {24'h0, m_stat};
      default: return 32'h0;
    endcase
  endfunction

  // Pin value seen two samples ago vs three samples ago defines an edge.
  task automatic model_edge();
    logic [7:0] wd, clr, rise, fall, ren0, fen0;
    wd   = bus.wdata[7:0];
    clr  = '0;
    rise = ph[1] & ~ph[2];
    fall = ~ph[1] & ph[2];
    ren0 = m_ren;
    fen0 = m_fen;
    if (bus.we && m_hit(bus.addr)) begin
      case (bus.addr - BASE)
        32'h00: m_out = wd;
        32'h04: m_dir = wd;
        32'h0C: m_out = m_out | wd;
        32'h10: m_out = m_out & ~wd;
        32'h14: m_out = m_out ^ wd;
        32'h18: m_ren = wd;
        32'h1C: m_fen = wd;
        32'h20: clr = wd;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | (rise & ren0) | (fall & fen0);
    ph.push_front(pins);
    void'(ph.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;
    rst       = 1'b1;
    pins      = '0;
    bus.addr  = BASE;
    bus.wdata = '0;
    bus.we    = 1'b0;
    model_reset();
    ticks(2);

    chk("rst_out", 32'(gout), 32'h0);
    chk("rst_oe", 32'(goe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_rd_out", BASE, 32'h0);
    rst = 1'b0;
    tick();

    wr(BASE + 32'h00, 32'h0000_00AA);
    wr(BASE + 32'h04, 32'h0000_00FF);
    chk("out_aa", 32'(gout), 32'hAA);
    chk("oe_ff", 32'(goe), 32'hFF);
    rd_chk("rd_out_aa", BASE, 32'hAA);

    wr(BASE + 32'h0C, 32'h05);
    chk("set", 32'(gout), 32'hAF);
    wr(BASE + 32'h10, 32'h0F);
    chk("clr", 32'(gout), 32'hA0);
    wr(BASE + 32'h14, 32'hFF);
    chk("tgl", 32'(gout), 32'h5F);
    rd_chk("rd_set", BASE + 32'h0C, 32'h0);
    rd_chk("rd_clr", BASE + 32'h10, 32'h0);
    rd_chk("rd_tgl", BASE + 32'h14, 32'h0);

    wr(BASE + 32'h18, 32'h01);
    pins = 8'h01;
    tick();
    rd_chk("in_k", BASE + 32'h08, 32'h0);
    tick();
    rd_chk("in_k1", BASE + 32'h08, 32'h01);
    chk("irq_k1", 32'(irq), 32'h0);
    tick();
    chk("irq_k2", 32'(irq), 32'h1);
    rd_chk("stat_k2", BASE + 32'h20, 32'h01);
    wr(BASE + 32'h20, 32'h01);
    chk("irq_w1c", 32'(irq), 32'h0);

    wr(BASE + 32'h18, 32'h00);
    wr(BASE + 32'h1C, 32'h80);
    pins = 8'h81;
    ticks(3);
    rd_chk("rise7_ignored", BASE + 32'h20, 32'h0);
    chk("rise7_irq", 32'(irq), 32'h0);
    pins = 8'h01;
    ticks(3);
    rd_chk("fall7", BASE + 32'h20, 32'h80);
    chk("fall7_irq", 32'(irq), 32'h1);
    wr(BASE + 32'h20, 32'h80);
    chk("fall7_clr", 32'(irq), 32'h0);

    wr(BASE + 32'h18, 32'h01);
    pins = 8'h00;
    ticks(3);
    pins = 8'h01;
    ticks(3);
    rd_chk("pre_race", BASE + 32'h20, 32'h01);
    pins = 8'h00;
    ticks(3);
    pins = 8'h01;
    ticks(2);
    wr(BASE + 32'h20, 32'h01);
    rd_chk("race_stat", BASE + 32'h20, 32'h01);
    chk("race_irq", 32'(irq), 32'h1);

    wr(BASE + 32'h24, 32'hDEAD_BEEF);
    wr(BASE + 32'h02, 32'hDEAD_BEEF);
    rd_chk("miss_24", BASE + 32'h24, 32'h0);
    rd_chk("miss_02", BASE + 32'h02, 32'h0);
    rd_chk("miss_below", BASE - 32'h4, 32'h0);
    chk("miss_out", 32'(gout), 32'h5F);
    chk("miss_oe", 32'(goe), 32'hFF);
    tick();
    rd_chk("miss_ren", BASE + 32'h18, 32'h01);
    rd_chk("miss_fen", BASE + 32'h1C, 32'h80);
    rd_chk("miss_stat", BASE + 32'h20, 32'h01);

    // Asynchronous reset between edges with irq pending
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_out", 32'(gout), 32'h0);
    chk("arst_oe", 32'(goe), 32'h0);
    rd_chk("arst_stat", BASE + 32'h20, 32'h0);
    pins = $urandom();
    tick();
    rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = BASE + 32'(($urandom() % 11) * 4);
      if ($urandom() % 8 == 0) a = a + 32'($urandom() % 4);
      if ($urandom() % 16 == 0) a = BASE - 32'h4;
      bus.addr  = a;
      bus.wdata = $urandom();
      bus.we    = ($urandom() % 2) == 1;
      if ($urandom() % 3 == 0) pins = $urandom();
      tick();
      bus.we = 1'b0;
      chk("rnd_out", 32'(gout), 32'(m_out));
      chk("rnd_oe", 32'(goe), 32'(m_dir));
      chk("rnd_irq", 32'(irq), 32'(m_stat != 0));
      a = BASE + 32'(($urandom() % 11) * 4);
      rd_chk("rnd_rd", a, m_read(a));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised memory-mapped GPIO controller, the successor to the single-register 8-bit GPIO. It sits on the CPU load/store bus and provides per-pin direction control and atomic set/clear/toggle of outputs. Inputs are synchronised, and rising/falling-edge capture drives a single level interrupt line to the core.

## Interface
- WIDTH, 8, number of GPIO pins (1..32)
- BASE_ADDR, 32'h0000_0030, byte address of register 0; must be 4-byte aligned
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  32  byte address from CPU
- wdata  in  32  write data
- we  in  1  write strobe, one cycle per write
- rdata  out  32  read data, combinational from addr and current register state
- gpio_in  in  WIDTH  asynchronous pad inputs
- gpio_out  out  WIDTH  output data to pads
- gpio_oe  out  WIDTH  per-pin output enable (1 = drive)
- irq  out  1  level interrupt, OR of pending status bits

## Operation
- Register map (offset from BASE_ADDR):
  - 0x00 OUT: RW output data.
  - 0x04 DIR: RW, 1 = output.
  - 0x08 IN: RO, synchronised pin value.
  - 0x0C SET: WO, OUT |= wdata.
  - 0x10 CLR: WO, OUT &= ~wdata.
  - 0x14 TGL: WO, OUT ^= wdata.
  - 0x18 RISE_EN: RW.
  - 0x1C FALL_EN: RW.
  - 0x20 STAT: RW1C pending edges.
- Hit when addr is BASE_ADDR+0x00..0x20 and addr[1:0]==0.
  - Misses and misaligned addresses: writes ignored, rdata = 0.
- Reads of SET/CLR/TGL return 0.
- Only wdata[WIDTH-1:0] is used; rdata[31:WIDTH] = 0.
- gpio_out = OUT and gpio_oe = DIR, both straight from flops. gpio_out is driven even when DIR = 0.
- Input path: two-flop synchroniser (s1, s2), then history flop p.
  - IN reads s2.
  - rise = s2 & ~p; fall = ~s2 & p.
- STAT next value per bit: (STAT & ~clr) | (rise & RISE_EN) | (fall & FALL_EN).
  - clr = wdata on a STAT write, else 0.
  - A new edge and W1C on the same bit in the same cycle: the edge wins and the bit stays 1.
- Disabling an enable does not clear already-pending STAT bits.
- irq = |STAT, registered (no extra stage beyond STAT).

## Timing
- Reset (async assert): OUT, DIR, RISE_EN, FALL_EN, STAT, s1, s2, p all 0.
  - gpio_out = 0, gpio_oe = 0, irq = 0.
  - rdata reflects the reset registers.
- Write with we high at rising edge N: register updates at edge N. New value is visible on outputs and rdata after edge N.
- rdata is combinational: valid in the same cycle addr is presented. No read strobe, no read side effects.
- Input change settling before edge k:
  - s1 updates at k.
  - s2 and IN update at k+1.
  - STAT bit and irq rise at k+2.
  - p updates at k+2.
- Pin high through reset release: s2 rises while p = 0, which counts as a rising edge. It is captured only if RISE_EN is already set, which after reset it is not.
- Pulses shorter than one clock may be missed. This is not an error.
- Reset asserted mid-operation clears pending STAT and irq immediately (async).

## Test plan
- Reset, write 0x000000AA to BASE+0x00 and 0xFF to BASE+0x04 -> gpio_out = 0xAA, gpio_oe = 0xFF; read BASE+0x00 = 0x000000AA.
- After OUT = 0xAA: write SET 0x05 -> 0xAF; CLR 0x0F -> 0xA0; TGL 0xFF -> 0x5F; reads of 0x0C/0x10/0x14 = 0.
- RISE_EN = 0x01, drive gpio_in[0] 0->1 -> IN bit 0 set 2 edges later, STAT = 0x01 and irq = 1 at the 3rd edge; write STAT 0x01 -> irq = 0 next cycle.
- FALL_EN = 0x80, gpio_in[7] 1->0 while RISE_EN = 0 -> STAT = 0x80; a rising edge on bit 7 does not set STAT.
- Same-cycle edge on bit 0 and W1C of STAT 0x01 -> STAT bit 0 stays 1, irq stays 1.
- Write 0xDEADBEEF to BASE+0x24 and to BASE+0x02 -> no register changes, reads return 0. Assert rst with irq = 1 -> irq, gpio_out, and gpio_oe go 0 without a clock edge.
